// File: rtl/mult_iter_param.sv
// Iterative radix-2^STEP_BITS multiplier for MULT/MULTU, with busy/flush handshake.
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module mult_iter_param #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             sign,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             valid_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int K  = WIDTH / STEP_BITS;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(K + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mc_q, mc_d;
    logic [WIDTH-1:0]  mp_q, mp_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     count_q, count_d;
    logic              neg_q, neg_d;
    logic              valid_out_q, valid_out_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic [PW-1:0]     step_ext;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     result;
    logic              early;
    logic              done;

    // Operand magnitudes and the partial product for the current multiplier digit
    always_comb begin
        abs_a    = (sign && src_a[WIDTH-1]) ? -src_a : src_a;
        abs_b    = (sign && src_b[WIDTH-1]) ? -src_b : src_b;
        step_ext = {{(PW-STEP_BITS){1'b0}}, mp_q[STEP_BITS-1:0]};
        pp       = step_ext * mc_q;
    end

    // Next-state, datapath update and completion; flush overrides everything
    always_comb begin
        state_d     = state_q;
        mc_d        = mc_q;
        mp_d        = mp_q;
        acc_d       = acc_q;
        count_d     = count_q;
        neg_d       = neg_q;
        valid_out_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        acc_next    = acc_q;
        result      = '0;
        early       = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_in && !flush) begin
                    state_d = RUN;
                    mc_d    = {{WIDTH{1'b0}}, abs_a};
                    mp_d    = abs_b;
                    acc_d   = '0;
                    count_d = '0;
                    neg_d   = sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                end
            end
            RUN: begin
`ifdef MULT_EARLY_TERM_EN
                early = (mp_q == '0);
`else
                early = 1'b0;
`endif
                if (early) begin
                    acc_next = acc_q;
                    done     = 1'b1;
                end else begin
                    acc_next = acc_q + pp;
                    mp_d     = mp_q >> STEP_BITS;
                    mc_d     = mc_q << STEP_BITS;
                    count_d  = count_q + CW'(1);
                    done     = (count_q == CW'(K - 1));
                end
                acc_d = acc_next;
                if (done) begin
                    state_d     = IDLE;
                    result      = neg_q ? -acc_next : acc_next;
                    hi_d        = result[PW-1:WIDTH];
                    lo_d        = result[WIDTH-1:0];
                    valid_out_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d     = IDLE;
            valid_out_d = 1'b0;
            hi_d        = hi_q;
            lo_d        = lo_q;
            acc_d       = '0;
            count_d     = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mc_q        <= '0;
            mp_q        <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            neg_q       <= 1'b0;
            valid_out_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            mc_q        <= mc_d;
            mp_q        <= mp_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            neg_q       <= neg_d;
            valid_out_q <= valid_out_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign valid_out = valid_out_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mult_iter_param.sv
// Bench for mult_iter_param (WIDTH=32, STEP_BITS=8).
// Vector table + scoreboard queue, plus flush/reset/back-to-back sequences.
module tb_mult_iter_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        sign;
    logic        flush;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        valid_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[$];

    mult_iter_param #(.WIDTH(32), .STEP_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .sign      (sign),
        .flush     (flush),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .valid_out (valid_out),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        longint x;
        if (s) begin
            x = longint'($signed(a)) * longint'($signed(b));
            return 64'(x);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int exp_lat(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int bl;
        int l;
        m  = (s && b[31]) ? -b : b;
        bl = 0;
        for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
`ifdef MULT_EARLY_TERM_EN
        l = 1 + (bl + 7) / 8;
        if (l > 4) l = 4;
`else
        l = 4 + 0 * bl;
`endif
        return l;
    endfunction

    // Every completion is checked against the oldest outstanding expectation
    always @(negedge clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid_out", 64'd1, 64'd0);
            end else begin
                chk("product", {hi, lo}, sb.pop_front());
            end
        end
    end

    task automatic wait_done(input string name, input int lat);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (valid_out) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
        else chk({name, "_latency"}, 64'(n), 64'(lat));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) return;
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        wait_idle();
        valid_in = 1'b1;
        src_a    = a;
        src_b    = b;
        sign     = s;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
        sb.push_back(exp);
        start(a, b, s);
        wait_done("op", exp_lat(b, s));
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] e);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.s   = s;
        v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        logic [63:0] old;
        logic [31:0] ra;
        logic [31:0] rb;

        reset    = 1'b1;
        valid_in = 1'b0;
        sign     = 1'b0;
        flush    = 1'b0;
        src_a    = '0;
        src_b    = '0;

        add(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        add(32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFF_FFFFFFF1);
        add(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        add(32'h80000000, 32'd2,        1'b0, 64'h00000001_00000000);
        add(32'd6,        32'd7,        1'b0, 64'd42);
        add(32'd7,        32'd1,        1'b1, 64'd7);
        add(32'd0,        32'h12345678, 1'b0, 64'd0);
        add(32'h12345678, 32'd0,        1'b1, 64'd0);
        add(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1);
        add(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
        add(32'd100,      32'h00000100, 1'b0, 64'd25600);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            add(ra, rb, i[0], model(ra, rb, i[0]));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp);

        // Operands held during busy must be ignored; next op accepted on valid_out
        sb.push_back(64'd42);
        wait_idle();
        valid_in = 1'b1;
        src_a    = 32'd6;
        src_b    = 32'd7;
        sign     = 1'b0;
        @(posedge clk);
        #1;
        src_a = 32'd9;
        src_b = 32'd9;
        wait_done("b2b_first", exp_lat(32'd7, 1'b0));
        chk("b2b_busy_low", 64'(busy), 64'd0);
        sb.push_back(64'd81);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        chk("b2b_accepted", 64'(busy), 64'd1);
        wait_done("b2b_second", exp_lat(32'd9, 1'b0));

        // Flush mid-operation
        old = {hi, lo};
        start(32'h01020304, 32'hFFFFFFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid_out", 64'(valid_out), 64'd0);
        chk("flush_hilo", {hi, lo}, old);
        repeat (6) @(posedge clk);
        #1;
        chk("flush_hilo_hold", {hi, lo}, old);

        // Flush and valid_in together in IDLE
        valid_in = 1'b1;
        flush    = 1'b1;
        src_a    = 32'd3;
        src_b    = 32'd3;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        flush    = 1'b0;
        chk("flush_vs_start", 64'(busy), 64'd0);

        // Flush on the completion edge
        start(32'd3, 32'hFFFFFFFF, 1'b0);
        repeat (exp_lat(32'hFFFFFFFF, 1'b0) - 1) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_done_valid", 64'(valid_out), 64'd0);
        chk("flush_done_hilo", {hi, lo}, old);
        chk("flush_done_busy", 64'(busy), 64'd0);

        // Ordinary op after flushes still works
        run_op(32'hFFFFFFF9, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFEB);

        // Reset mid-operation
        sb.push_back(64'd0);
        start(32'h55555555, 32'hAAAAAAAA, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_valid", 64'(valid_out), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
